// File: rtl/clb_pkg.sv
// Shared definitions for the CLB configuration loader: frame constants,
// FSM state codes and the LUT configuration word type.
package clb_pkg;

  localparam int         LUT_INPUTS_DEF = 4;
  localparam int         CFG_W          = 2 ** LUT_INPUTS_DEF;
  localparam int         CFG_BYTES      = CFG_W / 8;
  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
  localparam int         TIMEOUT_DEF    = 255;

  typedef logic [CFG_W-1:0] cfg_word_t;

  // Plain-constant state codes keep the encoding stable for older tools.
  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ADDR  = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_CHK   = 3'd3;
  localparam state_t ST_WRITE = 3'd4;

endpackage

// File: rtl/clb_cfg_timeout.sv
// Inter-byte watchdog: reloaded on every accepted byte, counts down on idle
// cycles inside a frame and flags expiry on the idle cycle that exhausts it.
module clb_cfg_timeout #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Reload on accept, otherwise count one idle cycle down per tick.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(TIMEOUT);
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign expire = tick && !load && (cnt_q == CNT_W'(1));

  // Counter register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clb_cfg_loader.sv
// Byte-serial configuration loader for the CLB LUT array. Collects framed
// packets (sync, address, data bytes little-endian, XOR checksum) and issues
// a single write into the LUT config registers per valid frame, keeping the
// CLB in config mode while a frame is in flight.
module clb_cfg_loader
  import clb_pkg::*;
#(
  parameter int         NUM_LUTS   = 8,
  parameter int         LUT_INPUTS = LUT_INPUTS_DEF,
  parameter int         ADDR_W     = 3,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter int         TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic                       cfg_we,
  output logic [ADDR_W-1:0]          cfg_addr,
  output logic [(2**LUT_INPUTS)-1:0] cfg_wdata,
  output logic                       cfg_mode,
  output logic                       frame_ok,
  output logic                       frame_err,
  output logic                       busy
);

  localparam int W      = 2 ** LUT_INPUTS;
  localparam int NBYTES = W / 8;
  localparam int CNT_W  = $clog2(NBYTES) + 1;
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  state_t            state_q,     state_d;
  logic [7:0]        addr_q,      addr_d;
  logic [7:0]        acc_q,       acc_d;
  logic [CNT_W-1:0]  byte_cnt_q,  byte_cnt_d;
  logic [W-1:0]      data_q,      data_d;
  logic              cfg_we_q,    cfg_we_d;
  logic [ADDR_W-1:0] cfg_addr_q,  cfg_addr_d;
  logic [W-1:0]      cfg_wdata_q, cfg_wdata_d;
  logic              cfg_mode_q,  cfg_mode_d;
  logic              frame_ok_q,  frame_ok_d;
  logic              frame_err_q, frame_err_d;

  logic accept;
  logic in_frame;
  logic to_tick;
  logic to_expire;
  logic addr_legal;

  assign rx_ready   = ena && (state_q != ST_WRITE);
  assign accept     = rx_valid && rx_ready;
  assign in_frame   = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_CHK);
  assign to_tick    = ena && in_frame && !accept;
  assign addr_legal = ({24'd0, addr_q} < 32'(NUM_LUTS));

  clb_cfg_timeout #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (TO_W)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .tick   (to_tick),
    .expire (to_expire)
  );

  // Frame FSM: everything holds while ena is low; strobes last one enabled cycle.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    acc_d       = acc_q;
    byte_cnt_d  = byte_cnt_q;
    data_d      = data_q;
    cfg_we_d    = cfg_we_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_wdata_d = cfg_wdata_q;
    cfg_mode_d  = cfg_mode_q;
    frame_ok_d  = frame_ok_q;
    frame_err_d = frame_err_q;

    if (ena) begin
      cfg_we_d   = 1'b0;
      frame_ok_d = 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (accept && (rx_data == SYNC_BYTE)) begin
            state_d     = ST_ADDR;
            frame_err_d = 1'b0;
            cfg_mode_d  = 1'b1;
            acc_d       = '0;
            byte_cnt_d  = '0;
          end
        end

        ST_ADDR: begin
          if (accept) begin
            addr_d     = rx_data;
            acc_d      = rx_data;
            byte_cnt_d = '0;
            state_d    = ST_DATA;
          end else if (to_expire) begin
            frame_err_d = 1'b1;
            cfg_mode_d  = 1'b0;
            state_d     = ST_IDLE;
          end
        end

        ST_DATA: begin
          if (accept) begin
            data_d     = (data_q >> 8) | (W'(rx_data) << (W - 8));
            acc_d      = acc_q ^ rx_data;
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (byte_cnt_q == CNT_W'(NBYTES - 1)) begin
              state_d = ST_CHK;
            end
          end else if (to_expire) begin
            frame_err_d = 1'b1;
            cfg_mode_d  = 1'b0;
            state_d     = ST_IDLE;
          end
        end

        ST_CHK: begin
          if (accept) begin
            if ((rx_data == acc_q) && addr_legal) begin
              state_d     = ST_WRITE;
              cfg_we_d    = 1'b1;
              frame_ok_d  = 1'b1;
              cfg_addr_d  = addr_q[ADDR_W-1:0];
              cfg_wdata_d = data_q;
            end else begin
              frame_err_d = 1'b1;
              cfg_mode_d  = 1'b0;
              state_d     = ST_IDLE;
            end
          end else if (to_expire) begin
            frame_err_d = 1'b1;
            cfg_mode_d  = 1'b0;
            state_d     = ST_IDLE;
          end
        end

        ST_WRITE: begin
          state_d    = ST_IDLE;
          cfg_mode_d = 1'b0;
        end

        default: begin
          state_d    = ST_IDLE;
          cfg_mode_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      acc_q       <= '0;
      byte_cnt_q  <= '0;
      data_q      <= '0;
      cfg_we_q    <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
      cfg_mode_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      acc_q       <= acc_d;
      byte_cnt_q  <= byte_cnt_d;
      data_q      <= data_d;
      cfg_we_q    <= cfg_we_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_wdata_q <= cfg_wdata_d;
      cfg_mode_q  <= cfg_mode_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign cfg_we    = cfg_we_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_wdata = cfg_wdata_q;
  assign cfg_mode  = cfg_mode_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
